// File: rtl/uart_apb_rx_drain.sv
// uart_apb_rx_drain: autonomous APB master for a CoreUARTapb slave.
// On cfg_start it writes the baud/mode registers. It then polls the UART
// status, either on the RXRDY pin hint or when a poll timer expires. Each
// received byte is moved into a local FIFO together with its error flags,
// and the FIFO is presented on a valid/ready stream.
module uart_apb_rx_drain #(
    parameter int FIFO_DEPTH  = 8,
    parameter int POLL_PERIOD = 1024
) (
    input  logic        PCLK,
    input  logic        PRESETN,
    input  logic        cfg_start,
    input  logic [12:0] cfg_baud,
    input  logic        cfg_bit8,
    input  logic        cfg_parity_en,
    input  logic        cfg_parity_odd,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [4:0]  PADDR,
    output logic [7:0]  PWDATA,
    input  logic [7:0]  PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR,
    input  logic        rxrdy_in,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic [2:0]  m_err,
    output logic        init_done,
    output logic [15:0] ovf_cnt,
    output logic [7:0]  bus_err_cnt
);

    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam logic [15:0] POLL_RELOAD = 16'(POLL_PERIOD - 1);
    localparam logic [AW:0] FIFO_FULL   = (AW + 1)'(FIFO_DEPTH);

    localparam logic [4:0] ADDR_RXDATA = 5'h04;
    localparam logic [4:0] ADDR_CTRL1  = 5'h08;
    localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
    localparam logic [4:0] ADDR_STATUS = 5'h10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CFG1    = 3'd1,
        ST_CFG2    = 3'd2,
        ST_WAIT    = 3'd3,
        ST_RD_STAT = 3'd4,
        ST_RD_DATA = 3'd5
    } state_t;

    state_t        state_r;
    logic          start_pend_r;
    logic [15:0]   poll_tmr_r;
    logic [2:0]    stat_err_r;
    logic [10:0]   mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;

    logic done_s;
    logic start_seen_s;
    logic fifo_full_s;
    logic go_cfg1_s;
    logic go_cfg2_s;
    logic go_stat_s;
    logic go_data_s;
    logic go_wait_s;
    logic push_s;
    logic pop_s;

    // Transfer completion and next-transfer decisions. A restart request
    // always wins and is only taken between transfers.
    always_comb begin
        done_s       = PSEL && PENABLE && PREADY;
        start_seen_s = cfg_start || start_pend_r;
        fifo_full_s  = (count_r == FIFO_FULL);
        go_cfg1_s    = start_seen_s && ((state_r == ST_IDLE) || (state_r == ST_WAIT) || done_s);
        go_cfg2_s    = !start_seen_s && done_s && (state_r == ST_CFG1);
        go_stat_s    = !start_seen_s && (state_r == ST_WAIT) &&
                       (rxrdy_in || (poll_tmr_r == 16'd0)) && !fifo_full_s;
        go_data_s    = !start_seen_s && done_s && (state_r == ST_RD_STAT) &&
                       !PSLVERR && PRDATA[1];
        go_wait_s    = done_s && !go_cfg1_s && !go_cfg2_s && !go_data_s;
        push_s       = done_s && (state_r == ST_RD_DATA) && !PSLVERR;
        pop_s        = (count_r != '0) && m_ready;
    end

    // Main sequencer: APB phase control, poll timer and init_done.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_r      <= ST_IDLE;
            start_pend_r <= 1'b0;
            poll_tmr_r   <= POLL_RELOAD;
            PSEL         <= 1'b0;
            PENABLE      <= 1'b0;
            PWRITE       <= 1'b0;
            PADDR        <= 5'h00;
            PWDATA       <= 8'h00;
            init_done    <= 1'b0;
        end else begin
            start_pend_r <= (start_pend_r || cfg_start) && !go_cfg1_s;
            if (go_cfg1_s) begin
                state_r   <= ST_CFG1;
                PSEL      <= 1'b1;
                PENABLE   <= 1'b0;
                PWRITE    <= 1'b1;
                PADDR     <= ADDR_CTRL1;
                PWDATA    <= cfg_baud[7:0];
                init_done <= 1'b0;
            end else if (go_cfg2_s) begin
                state_r <= ST_CFG2;
                PSEL    <= 1'b1;
                PENABLE <= 1'b0;
                PWRITE  <= 1'b1;
                PADDR   <= ADDR_CTRL2;
                PWDATA  <= {cfg_baud[12:8], cfg_parity_odd, cfg_parity_en, cfg_bit8};
            end else if (go_stat_s) begin
                state_r <= ST_RD_STAT;
                PSEL    <= 1'b1;
                PENABLE <= 1'b0;
                PWRITE  <= 1'b0;
                PADDR   <= ADDR_STATUS;
            end else if (go_data_s) begin
                state_r <= ST_RD_DATA;
                PSEL    <= 1'b1;
                PENABLE <= 1'b0;
                PWRITE  <= 1'b0;
                PADDR   <= ADDR_RXDATA;
            end else if (go_wait_s) begin
                state_r    <= ST_WAIT;
                PSEL       <= 1'b0;
                PENABLE    <= 1'b0;
                poll_tmr_r <= POLL_RELOAD;
                if (state_r == ST_CFG2) begin
                    init_done <= 1'b1;
                end else begin
                    init_done <= init_done;
                end
            end else if (PSEL && !PENABLE) begin
                PENABLE <= 1'b1;
            end else if ((state_r == ST_WAIT) && (poll_tmr_r != 16'd0)) begin
                poll_tmr_r <= poll_tmr_r - 16'd1;
            end else begin
                poll_tmr_r <= poll_tmr_r;
            end
        end
    end

    // Status error capture and the saturating event counters.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            stat_err_r  <= 3'b000;
            ovf_cnt     <= 16'h0000;
            bus_err_cnt <= 8'h00;
        end else begin
            if (done_s && PSLVERR && (bus_err_cnt != 8'hFF)) begin
                bus_err_cnt <= bus_err_cnt + 8'd1;
            end else begin
                bus_err_cnt <= bus_err_cnt;
            end
            if (done_s && !PSLVERR && (state_r == ST_RD_STAT)) begin
                stat_err_r <= {PRDATA[4], PRDATA[3], PRDATA[2]};
                if (PRDATA[3] && (ovf_cnt != 16'hFFFF)) begin
                    ovf_cnt <= ovf_cnt + 16'd1;
                end else begin
                    ovf_cnt <= ovf_cnt;
                end
            end else begin
                stat_err_r <= stat_err_r;
            end
        end
    end

    // Output FIFO storage and pointers; pointers wrap at FIFO_DEPTH.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 11'h000;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {stat_err_r, PRDATA};
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + (AW + 1)'(1);
            end else if (pop_s && !push_s) begin
                count_r <= count_r - (AW + 1)'(1);
            end else begin
                count_r <= count_r;
            end
        end
    end

    assign m_valid = (count_r != '0);
    assign m_data  = mem_r[rd_ptr_r][7:0];
    assign m_err   = mem_r[rd_ptr_r][10:8];

endmodule

// File: tb/tb_uart_apb_rx_drain.sv
// Directed bench for uart_apb_rx_drain with a small APB slave model that
// returns programmable status/data, inserts wait states and PSLVERR.
module tb_uart_apb_rx_drain;

    logic        PCLK = 1'b0;
    logic        PRESETN = 1'b0;
    logic        cfg_start = 1'b0;
    logic [12:0] cfg_baud = 13'h0000;
    logic        cfg_bit8 = 1'b0;
    logic        cfg_parity_en = 1'b0;
    logic        cfg_parity_odd = 1'b0;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [4:0]  PADDR;
    logic [7:0]  PWDATA;
    logic [7:0]  PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        rxrdy_in = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [7:0]  m_data;
    logic [2:0]  m_err;
    logic        init_done;
    logic [15:0] ovf_cnt;
    logic [7:0]  bus_err_cnt;

    // Slave model state
    logic [7:0] stat_val = 8'h00;
    logic [7:0] data_val = 8'h00;
    int         wait_n   = 0;
    logic       err_data = 1'b0;
    int         acc_cnt  = 0;
    int         n_wr     = 0;
    int         n_stat   = 0;
    int         n_data   = 0;
    logic [4:0] wr_addr [4];
    logic [7:0] wr_data [4];

    int checks = 0;
    int errors = 0;

    uart_apb_rx_drain #(.FIFO_DEPTH(8), .POLL_PERIOD(16)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .cfg_start(cfg_start), .cfg_baud(cfg_baud),
        .cfg_bit8(cfg_bit8), .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .rxrdy_in(rxrdy_in),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_err(m_err),
        .init_done(init_done), .ovf_cnt(ovf_cnt), .bus_err_cnt(bus_err_cnt)
    );

    always #5 PCLK = ~PCLK;

    assign PRDATA  = (PADDR == 5'h10) ? stat_val : data_val;
    assign PREADY  = (acc_cnt >= wait_n);
    assign PSLVERR = err_data && (PADDR == 5'h04) && PSEL && PENABLE && PREADY;

    // Slave wait-state counter and transaction log
    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
        if (PSEL && PENABLE && PREADY) begin
            if (PWRITE) begin
                if (n_wr < 4) begin
                    wr_addr[n_wr] <= PADDR;
                    wr_data[n_wr] <= PWDATA;
                end
                n_wr <= n_wr + 1;
            end else if (PADDR == 5'h10) begin
                n_stat <= n_stat + 1;
            end else if (PADDR == 5'h04) begin
                n_data <= n_data + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Starts a status+data read from WAIT with zero wait states; returns
    // once the status read has completed and clears the status value.
    task automatic rx_start(input logic [7:0] st, input logic [7:0] dt);
        for (int i = 0; i < 40; i++) begin
            @(negedge PCLK);
            if (!PSEL) break;
        end
        stat_val = st;
        data_val = dt;
        rxrdy_in = 1'b1;
        @(negedge PCLK);
        rxrdy_in = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        stat_val = 8'h00;
    endtask

    int s0, d0, cnt, nf, t0, t1;
    bit seen;

    initial begin
        // Reset state
        repeat (2) @(negedge PCLK);
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_mvalid", m_valid, 0);
        check("rst_init", init_done, 0);
        PRESETN = 1'b1;
        @(negedge PCLK);

        // Configuration sequence
        cfg_baud = 13'h1A5; cfg_bit8 = 1'b1; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b0;
        cfg_start = 1'b1;
        @(negedge PCLK);
        cfg_start = 1'b0;
        check("cfg1_setup_addr", PADDR, 5'h08);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (init_done) begin seen = 1'b1; break; end
            @(negedge PCLK);
        end
        check("init_done_seen", seen, 1);
        check("n_wr", n_wr, 2);
        check("wr0_addr", wr_addr[0], 5'h08);
        check("wr0_data", wr_data[0], 8'hA5);
        check("wr1_addr", wr_addr[1], 5'h0C);
        check("wr1_data", wr_data[1], 8'h0B);

        // Latency: rxrdy sampled in cycle 0
        m_ready = 1'b1;
        stat_val = 8'h02; data_val = 8'h5A; rxrdy_in = 1'b1;
        @(negedge PCLK);
        rxrdy_in = 1'b0;
        check("lat_c1_psel", PSEL, 1);
        check("lat_c1_pen", PENABLE, 0);
        check("lat_c1_addr", PADDR, 5'h10);
        @(negedge PCLK);
        check("lat_c2_pen", PENABLE, 1);
        @(negedge PCLK);
        stat_val = 8'h00;
        check("lat_c3_addr", PADDR, 5'h04);
        check("lat_c3_pen", PENABLE, 0);
        @(negedge PCLK);
        check("lat_c4_pen", PENABLE, 1);
        check("lat_c4_mvalid", m_valid, 0);
        @(negedge PCLK);
        check("lat_c5_mvalid", m_valid, 1);
        check("lat_c5_mdata", m_data, 8'h5A);
        check("lat_c5_merr", m_err, 3'b000);
        @(negedge PCLK);
        check("lat_c6_popped", m_valid, 0);

        // Error flags and overflow count
        m_ready = 1'b0;
        rx_start(8'h1E, 8'h33);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (m_valid) begin seen = 1'b1; break; end
            @(negedge PCLK);
        end
        check("err_mvalid", seen, 1);
        check("err_mdata", m_data, 8'h33);
        check("err_merr", m_err, 3'b111);
        check("err_ovf", ovf_cnt, 1);
        m_ready = 1'b1;
        @(negedge PCLK);
        m_ready = 1'b0;
        check("err_popped", m_valid, 0);

        // FIFO fill with rxrdy held high
        s0 = n_stat; d0 = n_data;
        stat_val = 8'h02; data_val = 8'h77; rxrdy_in = 1'b1;
        repeat (100) @(negedge PCLK);
        check("full_data_reads", n_data - d0, 8);
        check("full_stat_reads", n_stat - s0, 8);
        check("full_psel", PSEL, 0);
        check("full_head", m_data, 8'h77);
        repeat (10) @(negedge PCLK);
        check("full_still_8", n_data - d0, 8);
        m_ready = 1'b1;
        @(negedge PCLK);
        m_ready = 1'b0;
        repeat (20) @(negedge PCLK);
        check("pop1_data_reads", n_data - d0, 9);
        check("pop1_stat_reads", n_stat - s0, 9);
        rxrdy_in = 1'b0; stat_val = 8'h00;
        m_ready = 1'b1;
        repeat (12) @(negedge PCLK);
        check("drained", m_valid, 0);
        m_ready = 1'b0;

        // Wait states on a status read
        wait_n = 3;
        for (int i = 0; i < 40; i++) begin
            @(negedge PCLK);
            if (!PSEL) break;
        end
        rxrdy_in = 1'b1;
        cnt = 0;
        @(negedge PCLK);
        rxrdy_in = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (PSEL && PENABLE && (PADDR == 5'h10)) cnt++;
            @(negedge PCLK);
        end
        check("wait_access_cycles", cnt, 4);
        wait_n = 0;

        // PSLVERR on data read
        err_data = 1'b1;
        rx_start(8'h02, 8'h99);
        repeat (6) @(negedge PCLK);
        err_data = 1'b0;
        check("slverr_no_push", m_valid, 0);
        check("slverr_cnt", bus_err_cnt, 1);
        check("slverr_ovf_kept", ovf_cnt, 1);

        // Poll period with rxrdy low
        nf = 0; t0 = 0; t1 = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge PCLK);
            if (PSEL && !PENABLE && (PADDR == 5'h10)) begin
                if (nf == 0) t0 = i; else t1 = i;
                nf++;
                if (nf == 2) break;
            end
        end
        check("poll_found", nf, 2);
        check("poll_wait_cycles", t1 - t0 - 2, 16);

        // Asynchronous reset mid-access
        for (int i = 0; i < 40; i++) begin
            @(negedge PCLK);
            if (PSEL && PENABLE) break;
        end
        check("pre_rst_access", PSEL && PENABLE, 1);
        #2 PRESETN = 1'b0;
        #1;
        check("arst_psel", PSEL, 0);
        check("arst_penable", PENABLE, 0);
        check("arst_pwrite", PWRITE, 0);
        check("arst_paddr", PADDR, 0);
        check("arst_pwdata", PWDATA, 0);
        check("arst_init", init_done, 0);
        check("arst_ovf", ovf_cnt, 0);
        check("arst_buserr", bus_err_cnt, 0);
        check("arst_mvalid", m_valid, 0);
        check("arst_mdata", m_data, 0);
        @(negedge PCLK);
        PRESETN = 1'b1;
        s0 = n_stat;
        rxrdy_in = 1'b1;
        repeat (30) @(negedge PCLK);
        rxrdy_in = 1'b0;
        check("idle_no_reads", n_stat - s0, 0);
        check("idle_psel", PSEL, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_apb_rx_drain.md
Name: uart_apb_rx_drain

Overview:
- Autonomous APB master that sits directly upstream of a CoreUARTapb instance's APB slave port and consumes that UART's received data.
- On a start pulse it programs the UART baud/mode registers, then polls the UART status and drains RX bytes into a local FIFO.
- Bytes leave the FIFO on a valid/ready stream, each tagged with its error flags.
- Replaces BFM/CPU polling in subsystems with no processor on the UART bus.

Parameters:
FIFO_DEPTH, 8, output FIFO entries; power of 2, range 2..64
POLL_PERIOD, 1024, PCLK cycles in WAIT without rxrdy_in before a forced status read; range 2..65535

Ports:
PCLK  in  1  clock; all logic rising-edge
PRESETN  in  1  asynchronous active-low reset
cfg_start  in  1  one-cycle pulse: (re)program UART, then begin draining
cfg_baud  in  13  baud divisor
cfg_bit8  in  1  1 = 8 data bits
cfg_parity_en  in  1  parity enable
cfg_parity_odd  in  1  1 = odd parity
PSEL  out  1  APB select to UART
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  5  APB address
PWDATA  out  8  APB write data
PRDATA  in  8  APB read data
PREADY  in  1  APB ready; wait states allowed
PSLVERR  in  1  APB error
rxrdy_in  in  1  UART RXRDY pin, poll hint
m_valid  out  1  FIFO head valid
m_ready  in  1  consumer accepts head
m_data  out  8  received byte
m_err  out  3  {framing, overflow, parity} captured with byte
init_done  out  1  high once configuration writes complete
ovf_cnt  out  16  saturating count of status reads showing overflow
bus_err_cnt  out  8  saturating count of PSLVERR completions

Behaviour:
- UART register map (fixed): 0x04 RX data; 0x08 ctrl1 = cfg_baud[7:0]; 0x0C ctrl2 = {cfg_baud[12:8], cfg_parity_odd, cfg_parity_en, cfg_bit8}; 0x10 status.
- Status bits: bit1 RXRDY, bit2 parity error, bit3 overflow, bit4 framing error.
- Reset values: PSEL/PENABLE/PWRITE 0; PADDR 0; PWDATA 0; m_valid 0; m_data 0; m_err 0; init_done 0; both counters 0; FIFO empty; state IDLE.
- Reset is asynchronous and takes effect mid-transfer: PSEL drops immediately.
- APB transfer: setup cycle (PSEL=1, PENABLE=0), then access cycles (PENABLE=1) until PREADY=1. Address, data and direction stay stable across the transfer.
- PRDATA and PSLVERR are sampled on the PREADY=1 edge. Back-to-back transfers are allowed; there is no idle cycle between setup phases.
- States: IDLE, CFG1, CFG2, WAIT, RD_STAT, RD_DATA.
- Transitions:
  - IDLE waits for cfg_start.
  - CFG1 writes ctrl1, then CFG2 writes ctrl2.
  - After CFG2 completes: init_done=1, go to WAIT.
  - WAIT goes to RD_STAT when (rxrdy_in=1 or poll timer expired) and the FIFO is not full.
  - RD_STAT: if status bit1=1 go to RD_DATA, else WAIT.
  - RD_DATA pushes {status[4], status[3], status[2], PRDATA} into the FIFO on completion, then goes to WAIT.
- Poll timer:
  - Reloads on entry to WAIT.
  - Counts only in WAIT.
  - Expiry means POLL_PERIOD cycles elapsed.
- FIFO full: WAIT does not issue reads; the byte stays in the UART. The poll timer holds at expiry.
- Latency: rxrdy_in=1 sampled in WAIT at cycle 0, FIFO empty, PREADY=1 → status setup at cycle 1, access cycle 2, data setup cycle 3, access cycle 4, m_valid=1 at cycle 5.
- After a push, WAIT lasts at least 1 cycle so the RXRDY pin can deassert.
- PSLVERR on any transfer:
  - bus_err_cnt increments.
  - Read data is discarded; nothing is pushed to the FIFO.
  - RD_STAT or RD_DATA returns to WAIT.
  - A CFG write error still advances the configuration sequence.
- ovf_cnt increments on each error-free status read with bit3=1. Both counters saturate at their maximum.
- cfg_start during a transfer is latched and acted on after that transfer completes:
  - init_done clears.
  - State goes to CFG1.
  - FIFO contents are kept.
  - cfg_* inputs are sampled when the CFG1/CFG2 setup phases begin.
- FIFO pop: occurs when m_valid && m_ready.
- FIFO simultaneous push and pop when full: the push is impossible by construction, since no read is issued while full.
- FIFO simultaneous push and pop when empty: the pushed byte appears at the next cycle.
- FIFO pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Reset, pulse cfg_start with cfg_baud=0x1A5, bit8=1, parity_en=1, parity_odd=0 → write 0x08←0xA5, then 0x0C←0x0B; init_done=1 after second PREADY.
- Slave returns status 0x02 then data 0x5A, rxrdy_in pulse, m_ready=1 → m_valid at cycle 5 with m_data=0x5A, m_err=0.
- Status 0x1E (RXRDY, parity, overflow, framing), data 0x33 → m_err=3'b111, ovf_cnt=1.
- m_ready=0, rxrdy_in held 1, FIFO_DEPTH=8 → exactly 8 data reads; PSEL stays 0 afterwards. Pop one → exactly one further status+data read.
- PREADY low for 3 access cycles on a status read → PSEL/PENABLE/PADDR=0x10 held for 4 access cycles. PSLVERR on a data read → no push, bus_err_cnt=1.
- rxrdy_in=0, POLL_PERIOD=16 → status read every 16+ WAIT cycles. Assert PRESETN=0 mid-access → PSEL=0 immediately and all outputs at reset values.
